// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_pkg
// Description : Default 640x480@60 timing constants, the coordinate width,
//               the sync/blank flag bundle carried through the latency
//               delay line, and a count-window compare helper.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    localparam int COORD_W  = 10;

    localparam int H_ACTIVE = 640;
    localparam int H_FRONT  = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BACK   = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FRONT  = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BACK   = 33;

    localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam int MAX_X_PIXEL_COORD = H_ACTIVE - 1;
    localparam int MAX_Y_PIXEL_COORD = V_ACTIVE - 1;

    // Raw (undelayed, active-high) timing flags; travel together so that
    // blank and both syncs keep identical latency to the pins.
    typedef struct packed {
        logic active;
        logic hsync;
        logic vsync;
    } timing_flags_t;

    // True when start <= count < start+len. One extra bit on the upper
    // bound so the sum can never wrap.
    function automatic logic in_window(
        input logic [COORD_W-1:0] count,
        input logic [COORD_W-1:0] start,
        input logic [COORD_W-1:0] len
    );
        logic [COORD_W:0] w_end;
        w_end = {1'b0, start} + {1'b0, len};
        return ({1'b0, count} >= {1'b0, start}) && ({1'b0, count} < w_end);
    endfunction

endpackage
`default_nettype wire

// File: rtl/signal_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : signal_delay_line
// Description : DEPTH-stage shift register of WIDTH-bit words with
//               asynchronous active-low clear.
//   i_clk   in   1      clock, rising edge
//   i_rst_n in   1      asynchronous active-low clear of every stage
//   i_data  in   WIDTH  word entering stage 0
//   o_data  out  WIDTH  word after DEPTH clocks
//   o_tap   out  WIDTH  word after DEPTH-1 clocks (i_data when DEPTH=1)
// Revision    : 1.0 - initial release
// ============================================================================
module signal_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic [WIDTH-1:0] o_tap
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_data = r_stage[DEPTH-1];

    // The penultimate tap lets a downstream register consume the word one
    // clock early and still present it in step with o_data.
    generate
        if (DEPTH == 1) begin : g_tap_input
            assign o_tap = i_data;
        end else begin : g_tap_stage
            assign o_tap = r_stage[DEPTH-2];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/vga_timing_generator.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_generator
// Description : Walks pixel coordinates over a VGA frame for a pixel source,
//               registers the returned colour to the DAC and generates
//               hsync/vsync/blank aligned to the colour latency.
//   clock_i          in   1   pixel clock, rising edge
//   reset_i          in   1   asynchronous active-low reset
//   x_pixel_coord_o  out  10  column to pixel source (held at last visible)
//   y_pixel_coord_o  out  10  row to pixel source (held at last visible)
//   active_o         out  1   coordinate lies inside the visible area
//   frame_start_o    out  1   one-clock pulse at h=0, v=0
//   red/green/blue_i in   8   colour, PIXEL_LATENCY clocks after coordinate
//   vga_*_o colour   out  8   registered colour, 0 when blanked
//   vga_hsync_n_o    out  1   active-low horizontal sync
//   vga_vsync_n_o    out  1   active-low vertical sync
//   vga_blank_n_o    out  1   low during blanking
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_generator #(
    parameter int H_ACTIVE      = vga_timing_pkg::H_ACTIVE,
    parameter int H_FRONT       = vga_timing_pkg::H_FRONT,
    parameter int H_SYNC        = vga_timing_pkg::H_SYNC,
    parameter int H_BACK        = vga_timing_pkg::H_BACK,
    parameter int V_ACTIVE      = vga_timing_pkg::V_ACTIVE,
    parameter int V_FRONT       = vga_timing_pkg::V_FRONT,
    parameter int V_SYNC        = vga_timing_pkg::V_SYNC,
    parameter int V_BACK        = vga_timing_pkg::V_BACK,
    parameter int PIXEL_LATENCY = 1
) (
    input  logic                                clock_i,
    input  logic                                reset_i,
    output logic [vga_timing_pkg::COORD_W-1:0]  x_pixel_coord_o,
    output logic [vga_timing_pkg::COORD_W-1:0]  y_pixel_coord_o,
    output logic                                active_o,
    output logic                                frame_start_o,
    input  logic [7:0]                          red_i,
    input  logic [7:0]                          green_i,
    input  logic [7:0]                          blue_i,
    output logic [7:0]                          vga_red_o,
    output logic [7:0]                          vga_green_o,
    output logic [7:0]                          vga_blue_o,
    output logic                                vga_hsync_n_o,
    output logic                                vga_vsync_n_o,
    output logic                                vga_blank_n_o
);

    import vga_timing_pkg::*;

    localparam int c_H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int c_V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int c_DEPTH   = PIXEL_LATENCY + 1;

    localparam logic [COORD_W-1:0] c_H_LAST   = COORD_W'(c_H_TOTAL - 1);
    localparam logic [COORD_W-1:0] c_V_LAST   = COORD_W'(c_V_TOTAL - 1);
    localparam logic [COORD_W-1:0] c_H_ACTIVE = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] c_V_ACTIVE = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] c_MAX_X    = COORD_W'(H_ACTIVE - 1);
    localparam logic [COORD_W-1:0] c_MAX_Y    = COORD_W'(V_ACTIVE - 1);
    localparam logic [COORD_W-1:0] c_HS_START = COORD_W'(H_ACTIVE + H_FRONT);
    localparam logic [COORD_W-1:0] c_HS_LEN   = COORD_W'(H_SYNC);
    localparam logic [COORD_W-1:0] c_VS_START = COORD_W'(V_ACTIVE + V_FRONT);
    localparam logic [COORD_W-1:0] c_VS_LEN   = COORD_W'(V_SYNC);

    logic [COORD_W-1:0] r_h_count;
    logic [COORD_W-1:0] r_v_count;
    logic [COORD_W-1:0] w_h_next;
    logic [COORD_W-1:0] w_v_next;
    logic [COORD_W-1:0] r_x_coord;
    logic [COORD_W-1:0] r_y_coord;
    logic               r_active;
    logic               r_frame_start;

    timing_flags_t      w_raw_flags;
    timing_flags_t      w_dly_flags;
    timing_flags_t      w_tap_flags;
    logic [2:0]         w_raw_bits;
    logic [2:0]         w_dly_bits;
    logic [2:0]         w_tap_bits;
    logic               w_unused_tap;

    logic [7:0]         r_red;
    logic [7:0]         r_green;
    logic [7:0]         r_blue;

    // ------------------------------------------------------------------
    // Raster counters. v advances and wraps on the same edge as the h wrap.
    // ------------------------------------------------------------------
    always_comb begin
        w_h_next = r_h_count + COORD_W'(1);
        w_v_next = r_v_count;
        if (r_h_count == c_H_LAST) begin
            w_h_next = '0;
            w_v_next = (r_v_count == c_V_LAST) ? '0 : r_v_count + COORD_W'(1);
        end
    end

    // Coordinates, active and frame_start are derived from the next count
    // values so they are registered yet stay in step with the counters.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            r_h_count     <= '0;
            r_v_count     <= '0;
            r_x_coord     <= '0;
            r_y_coord     <= '0;
            r_active      <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_h_count     <= w_h_next;
            r_v_count     <= w_v_next;
            r_x_coord     <= (w_h_next < c_H_ACTIVE) ? w_h_next : c_MAX_X;
            r_y_coord     <= (w_v_next < c_V_ACTIVE) ? w_v_next : c_MAX_Y;
            r_active      <= (w_h_next < c_H_ACTIVE) && (w_v_next < c_V_ACTIVE);
            r_frame_start <= (w_h_next == '0) && (w_v_next == '0);
        end
    end

    assign x_pixel_coord_o = r_x_coord;
    assign y_pixel_coord_o = r_y_coord;
    assign active_o        = r_active;
    assign frame_start_o   = r_frame_start;

    // ------------------------------------------------------------------
    // Sync/blank alignment. r_active (not a fresh compare) feeds the line
    // so the delayed blank is also low while held in reset.
    // ------------------------------------------------------------------
    always_comb begin
        w_raw_flags        = '0;
        w_raw_flags.active = r_active;
        w_raw_flags.hsync  = in_window(r_h_count, c_HS_START, c_HS_LEN);
        w_raw_flags.vsync  = in_window(r_v_count, c_VS_START, c_VS_LEN);
    end

    assign w_raw_bits = w_raw_flags;

    signal_delay_line #(
        .WIDTH (3),
        .DEPTH (c_DEPTH)
    ) u_flag_delay (
        .i_clk   (clock_i),
        .i_rst_n (reset_i),
        .i_data  (w_raw_bits),
        .o_data  (w_dly_bits),
        .o_tap   (w_tap_bits)
    );

    assign w_dly_flags  = timing_flags_t'(w_dly_bits);
    assign w_tap_flags  = timing_flags_t'(w_tap_bits);
    assign w_unused_tap = w_tap_flags.hsync ^ w_tap_flags.vsync;

    // ------------------------------------------------------------------
    // Colour register. Incoming colour is PIXEL_LATENCY clocks behind its
    // coordinate, so it is gated by the active flag of that same age (the
    // penultimate tap); after this register both land on the pins together.
    // ------------------------------------------------------------------
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
        end else if (w_tap_flags.active) begin
            r_red   <= red_i;
            r_green <= green_i;
            r_blue  <= blue_i;
        end else begin
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
        end
    end

    assign vga_red_o     = r_red;
    assign vga_green_o   = r_green;
    assign vga_blue_o    = r_blue;
    assign vga_hsync_n_o = ~w_dly_flags.hsync;
    assign vga_vsync_n_o = ~w_dly_flags.vsync;
    assign vga_blank_n_o = w_dly_flags.active;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_generator.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_generator
// Description : Scoreboard bench. One instance with default 640x480 timing
//               and one with a small 25x10 raster so whole frames fit in a
//               short run. The stimulus process pushes the expected pin
//               state for every clock; a negedge monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_generator;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       active;
        logic       fs;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       hs_n;
        logic       vs_n;
        logic       blank_n;
    } obs_t;

    typedef struct packed {
        int ha; int hf; int hs; int hb;
        int va; int vf; int vs; int vb;
    } tim_t;

    typedef struct packed {
        int n; int x; int y; int act; int blank; int red;
    } pt_t;

    localparam tim_t BIG_T   = '{640, 16, 96, 48, 480, 10, 2, 33};
    localparam tim_t SMALL_T = '{16, 2, 4, 3, 6, 1, 2, 1};
    localparam obs_t RESET_OBS = '{x: 10'd0, y: 10'd0, active: 1'b0, fs: 1'b0,
                                   r: 8'd0, g: 8'd0, b: 8'd0,
                                   hs_n: 1'b1, vs_n: 1'b1, blank_n: 1'b0};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n = 0;
    int epoch = 0;
    int errors = 0;
    int checks = 0;

    obs_t big_q[$];
    obs_t small_q[$];

    // ---------------- default-timing instance ----------------
    logic [9:0] b_x, b_y;
    logic       b_act, b_fs, b_hs, b_vs, b_bl;
    logic [7:0] b_r, b_g, b_b, b_red_in, b_grn_in;
    obs_t       b_obs;

    vga_timing_generator u_dut (
        .clock_i         (clk),
        .reset_i         (rst_n),
        .x_pixel_coord_o (b_x),
        .y_pixel_coord_o (b_y),
        .active_o        (b_act),
        .frame_start_o   (b_fs),
        .red_i           (b_red_in),
        .green_i         (b_grn_in),
        .blue_i          (8'hA5),
        .vga_red_o       (b_r),
        .vga_green_o     (b_g),
        .vga_blue_o      (b_b),
        .vga_hsync_n_o   (b_hs),
        .vga_vsync_n_o   (b_vs),
        .vga_blank_n_o   (b_bl)
    );

    // ---------------- small-raster instance ----------------
    logic [9:0] s_x, s_y;
    logic       s_act, s_fs, s_hs, s_vs, s_bl;
    logic [7:0] s_r, s_g, s_b, s_red_in, s_grn_in;
    obs_t       s_obs;

    vga_timing_generator #(
        .H_ACTIVE (16), .H_FRONT (2), .H_SYNC (4), .H_BACK (3),
        .V_ACTIVE (6),  .V_FRONT (1), .V_SYNC (2), .V_BACK (1),
        .PIXEL_LATENCY (1)
    ) u_dut_small (
        .clock_i         (clk),
        .reset_i         (rst_n),
        .x_pixel_coord_o (s_x),
        .y_pixel_coord_o (s_y),
        .active_o        (s_act),
        .frame_start_o   (s_fs),
        .red_i           (s_red_in),
        .green_i         (s_grn_in),
        .blue_i          (8'hA5),
        .vga_red_o       (s_r),
        .vga_green_o     (s_g),
        .vga_blue_o      (s_b),
        .vga_hsync_n_o   (s_hs),
        .vga_vsync_n_o   (s_vs),
        .vga_blank_n_o   (s_bl)
    );

    assign b_obs = {b_x, b_y, b_act, b_fs, b_r, b_g, b_b, b_hs, b_vs, b_bl};
    assign s_obs = {s_x, s_y, s_act, s_fs, s_r, s_g, s_b, s_hs, s_vs, s_bl};

    // Pixel source stand-in: one-clock latency loopback of the coordinates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_red_in <= '0; b_grn_in <= '0;
            s_red_in <= '0; s_grn_in <= '0;
        end else begin
            b_red_in <= b_x[7:0]; b_grn_in <= b_y[7:0];
            s_red_in <= s_x[7:0]; s_grn_in <= s_y[7:0];
        end
    end

    // Expected pins k rising edges after reset release (k=0: in reset).
    // Coordinate at k from raster position; pins reflect position k-2.
    function automatic obs_t model(input tim_t t, input int k);
        obs_t o;
        int ht, vt, p, h, v, m;
        logic a;
        ht = t.ha + t.hf + t.hs + t.hb;
        vt = t.va + t.vf + t.vs + t.vb;
        o = RESET_OBS;
        if (k >= 1) begin
            p = k % (ht * vt); h = p % ht; v = p / ht;
            o.x      = 10'((h < t.ha) ? h : t.ha - 1);
            o.y      = 10'((v < t.va) ? v : t.va - 1);
            o.active = (h < t.ha) && (v < t.va);
            o.fs     = (p == 0);
        end
        if (k >= 3) begin
            m = k - 2;
            p = m % (ht * vt); h = p % ht; v = p / ht;
            a = (h < t.ha) && (v < t.va);
            o.blank_n = a;
            o.hs_n = !((h >= t.ha + t.hf) && (h < t.ha + t.hf + t.hs));
            o.vs_n = !((v >= t.va + t.vf) && (v < t.va + t.vf + t.vs));
            if (a) begin
                o.r = 8'(h);
                o.g = 8'(v);
                o.b = 8'hA5;
            end
        end
        return o;
    endfunction

    task automatic check_obs(input string name, input obs_t got, input obs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s n=%0d actual=%h required=%h", name, n, got, exp);
        end
    endtask

    task automatic check_val(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s n=%0d actual=%0d required=%0d", name, n, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) n++;
        else n = 0;
        big_q.push_back(model(BIG_T, n));
        small_q.push_back(model(SMALL_T, n));
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (big_q.size() > 0) check_obs("big_pins", b_obs, big_q.pop_front());
        if (small_q.size() > 0) check_obs("small_pins", s_obs, small_q.pop_front());
    end

    // Hand-computed points on the default raster (first epoch).
    pt_t pts [7] = '{
        '{1,   1,   0, 1, 0, 0},
        '{3,   3,   0, 1, 1, 1},
        '{639, 639, 0, 1, 1, 125},
        '{641, 639, 0, 0, 1, 127},
        '{642, 639, 0, 0, 0, 0},
        '{800, 0,   1, 1, 0, 0},
        '{802, 2,   1, 1, 1, 0}
    };

    int   b_hs_fall[$];
    int   s_fs0[$];
    int   s_fs1[$];
    int   b_hs_low = 0;
    int   s_vs_low = 0;
    int   s_vs_fall = -1;
    logic b_hs_prev = 1'b1;
    logic s_vs_prev = 1'b1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (epoch == 0) begin
                if (b_hs_prev && !b_hs) b_hs_fall.push_back(n);
                if (!b_hs && n <= 800) b_hs_low++;
                if (s_vs_prev && !s_vs && s_vs_fall < 0) s_vs_fall = n;
                if (!s_vs && n <= 250) s_vs_low++;
                if (s_fs) s_fs0.push_back(n);
                foreach (pts[i]) begin
                    if (pts[i].n == n) begin
                        check_val("pt_x", int'(b_x), pts[i].x);
                        check_val("pt_y", int'(b_y), pts[i].y);
                        check_val("pt_active", int'(b_act), pts[i].act);
                        check_val("pt_blank_n", int'(b_bl), pts[i].blank);
                        check_val("pt_red", int'(b_r), pts[i].red);
                    end
                end
            end else if (s_fs) begin
                s_fs1.push_back(n);
            end
        end
        b_hs_prev = b_hs;
        s_vs_prev = s_vs;
    end

    initial begin
        for (int i = 0; i < 3; i++) tick();
        #2 rst_n = 1'b1;
        for (int i = 0; i < 1900; i++) tick();

        // Default raster now at x=300, y=2: abort the frame asynchronously.
        #2 rst_n = 1'b0;
        n = 0;
        big_q.delete();
        small_q.delete();
        big_q.push_back(model(BIG_T, 0));
        small_q.push_back(model(SMALL_T, 0));
        #1;
        check_obs("async_reset_big", b_obs, RESET_OBS);
        check_obs("async_reset_small", s_obs, RESET_OBS);
        tick();
        tick();
        #2 rst_n = 1'b1;
        epoch = 1;
        for (int i = 0; i < 800; i++) tick();
        @(negedge clk);
        #1;

        check_val("hsync_first_fall", (b_hs_fall.size() > 0) ? b_hs_fall[0] : -1, 658);
        check_val("hsync_second_fall", (b_hs_fall.size() > 1) ? b_hs_fall[1] : -1, 1458);
        check_val("hsync_low_clocks", b_hs_low, 96);
        check_val("vsync_first_fall", s_vs_fall, 177);
        check_val("vsync_low_clocks", s_vs_low, 50);
        check_val("frame_start_first", (s_fs0.size() > 0) ? s_fs0[0] : -1, 250);
        check_val("frame_start_second", (s_fs0.size() > 1) ? s_fs0[1] : -1, 500);
        check_val("frame_start_count", s_fs0.size(), 7);
        check_val("frame_start_after_reset", (s_fs1.size() > 0) ? s_fs1[0] : -1, 250);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
